alu_issue_stage: RTL

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_if.sv | 35 +++
 rtl/alu_issue_stage.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Issue-stage bundle: upstream instruction handshake, ALU-side issue handshake,
// writeback port and illegal-opcode counter. "master" drives instructions/writeback.
interface alu_issue_if #(
   parameter int WIDTH = 32
);
   logic                    instr_valid;
   logic [31:0]             instr;
   logic                    instr_ready;
   logic                    ex_valid;
   logic                    ex_ready;
   logic signed [WIDTH-1:0] RS1;
   logic signed [WIDTH-1:0] RS2;
   logic [2:0]              Funct3;
   logic [6:0]              Funct7;
   logic [6:0]              opcode;
   logic [11:0]             Imm_reg;
   logic [4:0]              Shamt;
   logic [4:0]              rd_addr;
   logic                    wb_en;
   logic [4:0]              wb_addr;
   logic signed [WIDTH-1:0] wb_data;
   logic [7:0]              illegal_cnt;

   modport master (
      output instr_valid, instr, ex_ready, wb_en, wb_addr, wb_data,
      input  instr_ready, ex_valid, RS1, RS2, Funct3, Funct7, opcode,
             Imm_reg, Shamt, rd_addr, illegal_cnt
   );

   modport slave (
      input  instr_valid, instr, ex_ready, wb_en, wb_addr, wb_data,
      output instr_ready, ex_valid, RS1, RS2, Funct3, Funct7, opcode,
             Imm_reg, Shamt, rd_addr, illegal_cnt
   );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32 R/I-type issue stage: register file, decode, operand fetch with writeback
// bypass, and a one-entry output register that refreshes its operands while stalled.
module alu_issue_stage #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   alu_issue_if.slave bus
);

   localparam logic [6:0] OPC_R = 7'b0110011;
   localparam logic [6:0] OPC_I = 7'b0010011;

   logic signed [WIDTH-1:0] r_rf [32];

   logic                    r_vld_p1;
   logic signed [WIDTH-1:0] r_rs1_p1;
   logic signed [WIDTH-1:0] r_rs2_p1;
   logic [2:0]              r_funct3_p1;
   logic [6:0]              r_funct7_p1;
   logic [6:0]              r_opcode_p1;
   logic [11:0]             r_imm_p1;
   logic [4:0]              r_shamt_p1;
   logic [4:0]              r_rd_p1;
   logic [4:0]              r_rs1_idx_p1;
   logic [4:0]              r_rs2_idx_p1;
   logic [7:0]              r_illegal_cnt;

   logic                    w_ready;
   logic                    w_accept;
   logic                    w_is_r;
   logic                    w_is_i;
   logic                    w_legal;
   logic [4:0]              w_rs1_idx;
   logic [4:0]              w_rs2_idx;
   logic signed [WIDTH-1:0] w_rs1_val;
   logic signed [WIDTH-1:0] w_rs2_val;
   logic                    w_stall;
   logic                    w_wb_live;

   // Register read with x0 hard-wired and same-cycle writeback forwarding.
   function automatic logic signed [WIDTH-1:0] f_read_fwd(
      input logic [4:0]              idx,
      input logic signed [WIDTH-1:0] rf_val,
      input logic                    wb_en,
      input logic [4:0]              wb_addr,
      input logic signed [WIDTH-1:0] wb_data
   );
      if (idx == 5'd0)
         return '0;
      else if (wb_en && (wb_addr == idx))
         return wb_data;
      else
         return rf_val;
   endfunction

   function automatic logic [7:0] f_sat_inc(input logic [7:0] cnt);
      return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   endfunction

   assign w_ready   = !r_vld_p1 || bus.ex_ready;
   assign w_accept  = bus.instr_valid && w_ready;
   assign w_is_r    = (bus.instr[6:0] == OPC_R);
   assign w_is_i    = (bus.instr[6:0] == OPC_I);
   assign w_legal   = w_is_r || w_is_i;
   assign w_rs1_idx = bus.instr[19:15];
   assign w_rs2_idx = bus.instr[24:20];
   assign w_stall   = r_vld_p1 && !bus.ex_ready;
   assign w_wb_live = bus.wb_en && (bus.wb_addr != 5'd0);

   assign w_rs1_val = f_read_fwd(w_rs1_idx, r_rf[w_rs1_idx], bus.wb_en, bus.wb_addr, bus.wb_data);
   assign w_rs2_val = f_read_fwd(w_rs2_idx, r_rf[w_rs2_idx], bus.wb_en, bus.wb_addr, bus.wb_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) r_rf[i] <= '0;
      end else if (w_wb_live) begin
         r_rf[bus.wb_addr] <= bus.wb_data;
      end
   end

   // Stage p0 -> p1: decode/operand capture into the issue register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p1      <= 1'b0;
         r_rs1_p1      <= '0;
         r_rs2_p1      <= '0;
         r_funct3_p1   <= '0;
         r_funct7_p1   <= '0;
         r_opcode_p1   <= '0;
         r_imm_p1      <= '0;
         r_shamt_p1    <= '0;
         r_rd_p1       <= '0;
         r_rs1_idx_p1  <= '0;
         r_rs2_idx_p1  <= '0;
         r_illegal_cnt <= '0;
      end else if (w_accept && w_legal) begin
         r_vld_p1     <= 1'b1;
         r_rs1_p1     <= w_rs1_val;
         r_rs2_p1     <= w_is_r ? w_rs2_val : '0;
         r_funct3_p1  <= bus.instr[14:12];
         r_funct7_p1  <= bus.instr[31:25];
         r_opcode_p1  <= bus.instr[6:0];
         r_imm_p1     <= w_is_i ? bus.instr[31:20] : '0;
         r_shamt_p1   <= bus.instr[24:20];
         r_rd_p1      <= bus.instr[11:7];
         r_rs1_idx_p1 <= w_rs1_idx;
         r_rs2_idx_p1 <= w_rs2_idx;
      end else begin
         if (w_accept)
            r_illegal_cnt <= f_sat_inc(r_illegal_cnt);
         if (r_vld_p1 && bus.ex_ready) begin
            r_vld_p1 <= 1'b0;
         end else if (w_stall && w_wb_live) begin
            // A stalled op must not carry operands that went stale while it waited.
            if (bus.wb_addr == r_rs1_idx_p1)
               r_rs1_p1 <= bus.wb_data;
            if ((r_opcode_p1 == OPC_R) && (bus.wb_addr == r_rs2_idx_p1))
               r_rs2_p1 <= bus.wb_data;
         end
      end
   end

   assign bus.instr_ready = w_ready;
   assign bus.ex_valid    = r_vld_p1;
   assign bus.RS1         = r_rs1_p1;
   assign bus.RS2         = r_rs2_p1;
   assign bus.Funct3      = r_funct3_p1;
   assign bus.Funct7      = r_funct7_p1;
   assign bus.opcode      = r_opcode_p1;
   assign bus.Imm_reg     = r_imm_p1;
   assign bus.Shamt       = r_shamt_p1;
   assign bus.rd_addr     = r_rd_p1;
   assign bus.illegal_cnt = r_illegal_cnt;

endmodule
